// File: rtl/palette_pkg.sv
// ============================================================================
// palette_pkg : default 4-bit-per-channel palette and colour-depth expansion
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package palette_pkg;

  localparam int IDX_BG    = 0;
  localparam int IDX_NUM1  = 1;
  localparam int IDX_NUM2  = 2;
  localparam int IDX_NUM3  = 3;
  localparam int IDX_NUM4  = 4;
  localparam int IDX_NUM5  = 5;
  localparam int IDX_NUM6  = 6;
  localparam int IDX_NUM7  = 7;
  localparam int IDX_NUM8  = 8;
  localparam int IDX_RED   = 9;
  localparam int IDX_BLACK = 10;
  localparam int IDX_WHITE = 11;
  localparam int IDX_GRAY  = 12;

  localparam logic [11:0] C4_BG    = 12'hDDD;
  localparam logic [11:0] C4_NUM1  = 12'h11B;
  localparam logic [11:0] C4_NUM2  = 12'h0A6;
  localparam logic [11:0] C4_NUM3  = 12'h555;
  localparam logic [11:0] C4_NUM4  = 12'h413;
  localparam logic [11:0] C4_NUM5  = 12'h023;
  localparam logic [11:0] C4_NUM6  = 12'h999;
  localparam logic [11:0] C4_NUM7  = 12'hA51;
  localparam logic [11:0] C4_NUM8  = 12'h000;
  localparam logic [11:0] C4_RED   = 12'hF00;
  localparam logic [11:0] C4_BLACK = 12'h111;
  localparam logic [11:0] C4_WHITE = 12'hFFF;
  localparam logic [11:0] C4_GRAY  = 12'h555;

  function automatic logic [11:0] default_colour4(input int unsigned idx);
    logic [11:0] c;
    case (idx)
      IDX_BG:    c = C4_BG;
      IDX_NUM1:  c = C4_NUM1;
      IDX_NUM2:  c = C4_NUM2;
      IDX_NUM3:  c = C4_NUM3;
      IDX_NUM4:  c = C4_NUM4;
      IDX_NUM5:  c = C4_NUM5;
      IDX_NUM6:  c = C4_NUM6;
      IDX_NUM7:  c = C4_NUM7;
      IDX_NUM8:  c = C4_NUM8;
      IDX_RED:   c = C4_RED;
      IDX_BLACK: c = C4_BLACK;
      IDX_WHITE: c = C4_WHITE;
      IDX_GRAY:  c = C4_GRAY;
      default:   c = 12'h000;
    endcase
    return c;
  endfunction

  // Result is right-aligned in 8 bits: wider depths replicate the nibble,
  // narrower ones keep its MSBs.
  function automatic logic [7:0] expand_channel(input logic [3:0] v, input int unsigned w);
    logic [7:0] r;
    if (w >= 4) r = {v, v} >> (8 - w);
    else        r = {4'b0000, v} >> (4 - w);
    return r;
  endfunction

  function automatic logic [23:0] expand_colour(input logic [11:0] c4, input int unsigned w);
    return {expand_channel(c4[11:8], w), expand_channel(c4[7:4], w), expand_channel(c4[3:0], w)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/blink_timer.sv
// ============================================================================
// blink_timer : vsync rising-edge detect, frame counter and blink phase toggle
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic blink_phase
);

  localparam int               CNT_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             vsync_prev_q;
  logic             vsync_prev_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             phase_q;
  logic             phase_d;
  logic             vsync_rise;

  always_comb begin
    vsync_rise   = vsync & ~vsync_prev_q;
    vsync_prev_d = vsync;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    if (vsync_rise) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_q <= 1'b0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/palette_lut.sv
// ============================================================================
// palette_lut : 2-stage palette lookup with blink inversion and blanking.
//               PALETTE_WR_EN adds a runtime write port to the palette.
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module palette_lut
  import palette_pkg::*;
#(
  parameter int COLOUR_W     = 4,
  parameter int NUM_ENTRIES  = 16,
  parameter int IDX_W        = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_blink,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic                  in_blank,
`ifdef PALETTE_WR_EN
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [3*COLOUR_W-1:0] wr_data,
`endif
  output logic [3*COLOUR_W-1:0] rgb_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  blank_out,
  output logic                  blink_phase
);

  localparam int RGB_W = 3 * COLOUR_W;

  function automatic logic [RGB_W-1:0] default_rgb(input int unsigned idx);
    logic [23:0] e;
    e = expand_colour(default_colour4(idx), COLOUR_W);
    return {COLOUR_W'(e[23:16]), COLOUR_W'(e[15:8]), COLOUR_W'(e[7:0])};
  endfunction

  logic [RGB_W-1:0] palette [NUM_ENTRIES];

`ifdef PALETTE_WR_EN
  logic [RGB_W-1:0] palette_q [NUM_ENTRIES];
  logic [RGB_W-1:0] palette_d [NUM_ENTRIES];

  // Address compare per entry: out-of-range write addresses match nothing.
  always_comb begin
    palette_d = palette_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (wr_en && (wr_addr == IDX_W'(i))) palette_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) palette_q[i] <= default_rgb(i);
    end else begin
      palette_q <= palette_d;
    end
  end

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    assign palette[gi] = palette_q[gi];
  end
`else
  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_rom
    assign palette[gi] = default_rgb(gi);
  end
`endif

  logic [RGB_W-1:0] rd_colour;

  always_comb begin
    rd_colour = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (in_idx == IDX_W'(i)) rd_colour = palette[i];
    end
  end

  // Stage 1: palette read and timing capture
  logic [RGB_W-1:0] colour_s1_q, colour_s1_d;
  logic             blink_s1_q, blink_s1_d;
  logic             hsync_s1_q, hsync_s1_d;
  logic             vsync_s1_q, vsync_s1_d;
  logic             blank_s1_q, blank_s1_d;

  // Stage 2: output colour and aligned timing
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             blank_q, blank_d;

  logic             phase;

  blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink_timer (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync_s1_q),
    .blink_phase (phase)
  );

  always_comb begin
    colour_s1_d = rd_colour;
    blink_s1_d  = in_blink;
    hsync_s1_d  = in_hsync;
    vsync_s1_d  = in_vsync;
    blank_s1_d  = in_blank;

    hsync_d = hsync_s1_q;
    vsync_d = vsync_s1_q;
    blank_d = blank_s1_q;
    if (blank_s1_q)                rgb_d = '0;
    else if (blink_s1_q && phase)  rgb_d = ~colour_s1_q;
    else                           rgb_d = colour_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      colour_s1_q <= '0;
      blink_s1_q  <= 1'b0;
      hsync_s1_q  <= 1'b0;
      vsync_s1_q  <= 1'b0;
      blank_s1_q  <= 1'b0;
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      colour_s1_q <= colour_s1_d;
      blink_s1_q  <= blink_s1_d;
      hsync_s1_q  <= hsync_s1_d;
      vsync_s1_q  <= vsync_s1_d;
      blank_s1_q  <= blank_s1_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      blank_q     <= blank_d;
    end
  end

  assign rgb_out     = rgb_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign blank_out   = blank_q;
  assign blink_phase = phase;

endmodule

`default_nettype wire

// File: tb/tb_palette_lut.sv
// ============================================================================
// tb_palette_lut : randomized self-checking bench with a behavioural model
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tb_palette_lut;

  localparam int CW = 8;
  localparam int NE = 12;
  localparam int IW = 4;
  localparam int BF = 2;
  localparam int RW = 3 * CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] in_idx = '0;
  logic          in_blink = 1'b0;
  logic          in_hsync = 1'b0;
  logic          in_vsync = 1'b0;
  logic          in_blank = 1'b0;
`ifdef PALETTE_WR_EN
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [RW-1:0] wr_data = '0;
`endif
  logic [RW-1:0] rgb_out;
  logic          hsync_out;
  logic          vsync_out;
  logic          blank_out;
  logic          blink_phase;

  always #5 clk = ~clk;

  palette_lut #(
    .COLOUR_W     (CW),
    .NUM_ENTRIES  (NE),
    .IDX_W        (IW),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_idx      (in_idx),
    .in_blink    (in_blink),
    .in_hsync    (in_hsync),
    .in_vsync    (in_vsync),
    .in_blank    (in_blank),
`ifdef PALETTE_WR_EN
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`endif
    .rgb_out     (rgb_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .blank_out   (blank_out),
    .blink_phase (blink_phase)
  );

  typedef struct packed {
    logic [RW-1:0] rgb;
    logic          hs;
    logic          vs;
    logic          bl;
  } exp_t;

  exp_t          exp_q[$];
  logic [11:0]   def4    [16];
  logic [RW-1:0] mdl_pal [16];
  int            edges;
  logic          prev_vs;
  int            errors = 0;
  int            checks = 0;

  // 4-bit nibble to 8-bit by repetition (n * 17)
  function automatic logic [RW-1:0] x8(input logic [11:0] c);
    return {c[11:8] * 8'd17, c[7:4] * 8'd17, c[3:0] * 8'd17};
  endfunction

  function automatic logic mdl_phase();
    return ((edges / BF) % 2) == 1;
  endfunction

  function automatic exp_t model(input int idx, input logic blink, hs, vs, blank);
    exp_t          e;
    logic [RW-1:0] c;
    c = (idx < NE) ? mdl_pal[idx] : '0;
    if (blank)                     e.rgb = '0;
    else if (blink && mdl_phase()) e.rgb = ~c;
    else                           e.rgb = c;
    e.hs = hs;
    e.vs = vs;
    e.bl = blank;
    return e;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl_pal[i] = (i < NE) ? x8(def4[i]) : '0;
    edges   = 0;
    prev_vs = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);  // stage 1 holds a flushed pixel
  endtask

  task automatic drive(input int idx, input logic blink, hs, vs, blank);
    in_idx   = IW'(idx);
    in_blink = blink;
    in_hsync = hs;
    in_vsync = vs;
    in_blank = blank;
    exp_q.push_back(model(idx, blink, hs, vs, blank));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (in_vsync && !prev_vs) edges++;
      prev_vs = in_vsync;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_idx = IW'($urandom_range(0, 15)); in_hsync = 1'b1; in_blank = 1'b1;
      tick();
      checks++;
      if ({rgb_out, hsync_out, vsync_out, blank_out, blink_phase} !== '0) begin
        errors++;
        $display("FAIL reset: got rgb=%h hs=%b vs=%b bl=%b ph=%b, want all 0",
                 rgb_out, hsync_out, vsync_out, blank_out, blink_phase);
      end
    end
    in_hsync = 1'b0; in_blank = 1'b0;
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic test_sweep();
    exp_t e;
    for (int t = 0; t < 18; t++) begin
      if (t < 16) drive(t, 1'b0, 1'b0, 1'b0, 1'b0);
      else        drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({rgb_out, hsync_out, vsync_out, blank_out} !== e) begin
        errors++;
        $display("FAIL sweep t=%0d: got %h/%b%b%b, want %h/%b%b%b", t, rgb_out,
                 hsync_out, vsync_out, blank_out, e.rgb, e.hs, e.vs, e.bl);
      end
      if (t == 2) begin
        checks++;
        if (rgb_out !== 24'h1111BB) begin
          errors++;
          $display("FAIL sweep_idx1: got %h, want 1111bb", rgb_out);
        end
      end
    end
  endtask

  task automatic test_blank();
    exp_t e;
    int   pat [8][5] = '{'{9,0,1,0,1}, '{9,0,0,0,0}, '{9,1,0,1,1}, '{9,0,0,1,0},
                         '{11,0,1,0,1}, '{3,0,0,0,0}, '{0,0,0,0,1}, '{0,0,0,0,1}};
    for (int t = 0; t < 8; t++) begin
      drive(pat[t][0], 1'b0, pat[t][2][0], pat[t][3][0], pat[t][4][0]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({rgb_out, hsync_out, vsync_out, blank_out} !== e) begin
        errors++;
        $display("FAIL blank t=%0d: got %h/%b%b%b, want %h/%b%b%b", t, rgb_out,
                 hsync_out, vsync_out, blank_out, e.rgb, e.hs, e.vs, e.bl);
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    for (int f = 0; f < 6; f++) begin
      for (int t = 0; t < 9; t++) begin
        if (t < 6)      drive((t == 4) ? 2 : 11, (t % 2) == 0, 1'b0, 1'b0, 1'b0);
        else if (t < 8) drive(0, 1'b0, 1'b0, 1'b1, 1'b1);
        else            drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({rgb_out, hsync_out, vsync_out, blank_out} !== e) begin
          errors++;
          $display("FAIL blink f=%0d t=%0d: got %h/%b%b%b, want %h/%b%b%b", f, t, rgb_out,
                   hsync_out, vsync_out, blank_out, e.rgb, e.hs, e.vs, e.bl);
        end
        if (t == 5) begin
          checks++;
          if (blink_phase !== mdl_phase()) begin
            errors++;
            $display("FAIL blink_phase f=%0d: got %b, want %b", f, blink_phase, mdl_phase());
          end
        end
      end
    end
  endtask

`ifdef PALETTE_WR_EN
  task automatic test_write();
    exp_t e;
    for (int t = 0; t < 20; t++) begin
      wr_en = 1'b0;
      case (t)
        0: begin
          drive(3, 1'b0, 1'b0, 1'b0, 1'b0);
          wr_en = 1'b1; wr_addr = 4'd3; wr_data = 24'h00FF00;
          mdl_pal[3] = 24'h00FF00;
        end
        1: drive(3, 1'b0, 1'b0, 1'b0, 1'b0);
        2: begin
          drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
          wr_en = 1'b1; wr_addr = 4'd15; wr_data = 24'hFFFFFF;
        end
        default: drive((t < 19) ? t - 3 : 0, 1'b0, 1'b0, 1'b0, t >= 19);
      endcase
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({rgb_out, hsync_out, vsync_out, blank_out} !== e) begin
        errors++;
        $display("FAIL write t=%0d: got %h/%b%b%b, want %h/%b%b%b", t, rgb_out,
                 hsync_out, vsync_out, blank_out, e.rgb, e.hs, e.vs, e.bl);
      end
    end
    wr_en = 1'b0;
  endtask
`endif

  task automatic test_random();
    exp_t e;
    for (int t = 0; t < 400; t++) begin
`ifdef PALETTE_WR_EN
      wr_en = 1'b0;
`endif
      drive($urandom_range(0, 15), 1'($urandom), 1'($urandom),
            $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
`ifdef PALETTE_WR_EN
      if ($urandom_range(0, 7) == 0) begin
        wr_en   = 1'b1;
        wr_addr = IW'($urandom_range(0, 15));
        wr_data = RW'($urandom);
        if (int'(wr_addr) < NE) mdl_pal[wr_addr] = wr_data;
      end
`endif
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({rgb_out, hsync_out, vsync_out, blank_out} !== e) begin
        errors++;
        $display("FAIL random t=%0d: got %h/%b%b%b, want %h/%b%b%b", t, rgb_out,
                 hsync_out, vsync_out, blank_out, e.rgb, e.hs, e.vs, e.bl);
      end
    end
`ifdef PALETTE_WR_EN
    wr_en = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n;
    // Park the blink state at phase 1 with a partly advanced counter.
    n = 0;
    while ((edges % 4) != 3 && n < 8) begin
      drive(0, 1'b0, 1'b0, n % 2 == 0, 1'b1);
      tick();
      void'(exp_q.pop_front());
      n++;
    end
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1); tick(); void'(exp_q.pop_front());
`ifdef PALETTE_WR_EN
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 24'h123456;
`endif
    drive(2, 1'b1, 1'b1, 1'b0, 1'b0); tick(); void'(exp_q.pop_front());
`ifdef PALETTE_WR_EN
    wr_en = 1'b0;
`endif
    drive(2, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({rgb_out, hsync_out, vsync_out, blank_out, blink_phase} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got rgb=%h hs=%b vs=%b bl=%b ph=%b, want all 0",
               rgb_out, hsync_out, vsync_out, blank_out, blink_phase);
    end
    rst = 1'b0;
    mdl_reset();
    for (int t = 0; t < 16; t++) begin
      if (t < 2)       drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
      else if (t == 3) drive(0, 1'b0, 1'b0, 1'b1, 1'b1);
      else             drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({rgb_out, hsync_out, vsync_out, blank_out} !== e) begin
        errors++;
        $display("FAIL post_reset t=%0d: got %h/%b%b%b, want %h/%b%b%b", t, rgb_out,
                 hsync_out, vsync_out, blank_out, e.rgb, e.hs, e.vs, e.bl);
      end
      if (t == 1) begin
        checks++;
        if (rgb_out !== 24'h00AA66) begin
          errors++;
          $display("FAIL post_reset_entry2: got %h, want 00aa66", rgb_out);
        end
      end
      if (t == 15) begin
        checks++;
        if (blink_phase !== 1'b0) begin
          errors++;
          $display("FAIL post_reset_phase: got %b, want 0", blink_phase);
        end
      end
    end
  endtask

  initial begin
    def4 = '{12'hDDD, 12'h11B, 12'h0A6, 12'h555, 12'h413, 12'h023, 12'h999, 12'hA51,
             12'h000, 12'hF00, 12'h111, 12'hFFF, 12'h555, 12'h000, 12'h000, 12'h000};
    mdl_reset();
    test_reset();
    test_sweep();
    test_blank();
    test_blink();
`ifdef PALETTE_WR_EN
    test_write();
`endif
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
